i2c_target: RTL and testbench

// - I2C target (responder) at the far end of the bus from the i2c_controller. Presents an
//   8-bit-addressed register space to the system over SCL/SDA, PCA9685-style.
// - Oversamples SCL/SDA on clk_i, decodes START/STOP, matches the 7-bit address, ACKs and

---
 rtl/i2c_target.sv | 237 +++++++++++++++++++++++
 tb/tb_i2c_target.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_target.sv
// ============================================================================
// Module   : i2c_target
// Purpose  : I2C target with 8-bit register pointer, write/read strobes, auto-increment.
//            Optional read path is built when I2C_TARGET_READ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module i2c_target #(
  parameter logic [6:0]  TARGET_ADDR = 7'h40,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe_o,
  output logic [7:0] reg_addr_o,
  output logic [7:0] reg_wdata_o,
  output logic       reg_wr_o,
  output logic       reg_rd_o,
  input  logic [7:0] reg_rdata_i,
  output logic       busy_o
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_ADDR      = 4'd1,
    S_ADDR_ACK  = 4'd2,
    S_REG       = 4'd3,
    S_REG_ACK   = 4'd4,
    S_WDATA     = 4'd5,
    S_WDATA_ACK = 4'd6,
    S_RDATA     = 4'd7,
    S_RDATA_ACK = 4'd8,
    S_IGNORE    = 4'd9
  } state_t;

  // Synchronizers reset to the idle-bus level so reset release creates no edges.
  logic [SYNC_STAGES-1:0] r_scl_sync, r_sda_sync;
  logic                   r_scl_hist, r_sda_hist;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_hist <= 1'b1;
      r_sda_hist <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_hist <= r_scl_sync[SYNC_STAGES-1];
      r_sda_hist <= r_sda_sync[SYNC_STAGES-1];
    end
  end

  logic w_scl, w_sda, w_scl_rise, w_scl_fall, w_sda_rise, w_sda_fall, w_start, w_stop;
  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign w_scl_rise = w_scl & ~r_scl_hist;
  assign w_scl_fall = ~w_scl & r_scl_hist;
  assign w_sda_rise = w_sda & ~r_sda_hist;
  assign w_sda_fall = ~w_sda & r_sda_hist;
  // SCL must be steadily high; an SDA edge coinciding with an SCL edge is data.
  assign w_start    = w_sda_fall & w_scl & r_scl_hist;
  assign w_stop     = w_sda_rise & w_scl & r_scl_hist;

  state_t     r_state;
  logic [3:0] r_bit_cnt;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [7:0] r_wdata;
  logic       r_wr;
  logic       r_oe;
  logic       r_busy;
  logic       w_addr_ok;

`ifdef I2C_TARGET_READ_EN
  logic r_rd;
  logic r_rw;
  logic r_ack;
  assign w_addr_ok = (r_shift[7:1] == TARGET_ADDR);
  assign reg_rd_o  = r_rd;
`else
  logic w_unused_rdata;
  assign w_addr_ok      = (r_shift[7:1] == TARGET_ADDR) && !r_shift[0];
  assign reg_rd_o       = 1'b0;
  assign w_unused_rdata = ^reg_rdata_i;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= 4'd0;
      r_shift   <= 8'h00;
      r_ptr     <= 8'h00;
      r_wdata   <= 8'h00;
      r_wr      <= 1'b0;
      r_oe      <= 1'b0;
      r_busy    <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      r_rd      <= 1'b0;
      r_rw      <= 1'b0;
      r_ack     <= 1'b0;
`endif
    end else begin
      r_wr <= 1'b0;
`ifdef I2C_TARGET_READ_EN
      r_rd <= 1'b0;
`endif
      if (r_wr) r_ptr <= r_ptr + 8'd1;

      if (w_start) begin
        r_state   <= S_ADDR;
        r_bit_cnt <= 4'd0;
        r_oe      <= 1'b0;
      end else if (w_stop) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 4'd0;
        r_oe      <= 1'b0;
        r_busy    <= 1'b0;
      end else begin
        case (r_state)
          S_ADDR: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_bit_cnt <= 4'd0;
              if (w_addr_ok) begin
                r_oe    <= 1'b1;
                r_busy  <= 1'b1;
                r_state <= S_ADDR_ACK;
`ifdef I2C_TARGET_READ_EN
                r_rw    <= r_shift[0];
`endif
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end
          S_ADDR_ACK: begin
            if (w_scl_fall) begin
              r_bit_cnt <= 4'd0;
`ifdef I2C_TARGET_READ_EN
              if (r_rw) begin
                r_rd    <= 1'b1;
                r_state <= S_RDATA;
              end else
`endif
              begin
                r_oe    <= 1'b0;
                r_state <= S_REG;
              end
            end
          end
          S_REG: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_ptr     <= r_shift;
              r_oe      <= 1'b1;
              r_bit_cnt <= 4'd0;
              r_state   <= S_REG_ACK;
            end
          end
          S_REG_ACK, S_WDATA_ACK: begin
            if (w_scl_fall) begin
              r_oe    <= 1'b0;
              r_state <= S_WDATA;
            end
          end
          S_WDATA: begin
            if (w_scl_rise) begin
              r_shift   <= {r_shift[6:0], w_sda};
              r_bit_cnt <= r_bit_cnt + 4'd1;
              if (r_bit_cnt == 4'd7) begin
                r_wdata <= {r_shift[6:0], w_sda};
                r_wr    <= 1'b1;
              end
            end else if (w_scl_fall && r_bit_cnt == 4'd8) begin
              r_oe      <= 1'b1;
              r_bit_cnt <= 4'd0;
              r_state   <= S_WDATA_ACK;
            end
          end
`ifdef I2C_TARGET_READ_EN
          S_RDATA: begin
            // The strobe cycle is when reg_rdata_i is valid for the current pointer.
            if (r_rd) begin
              r_shift <= reg_rdata_i;
              r_oe    <= ~reg_rdata_i[7];
              r_ptr   <= r_ptr + 8'd1;
            end else if (w_scl_fall) begin
              if (r_bit_cnt == 4'd7) begin
                r_oe      <= 1'b0;
                r_bit_cnt <= 4'd0;
                r_state   <= S_RDATA_ACK;
              end else begin
                r_shift   <= {r_shift[6:0], 1'b0};
                r_oe      <= ~r_shift[6];
                r_bit_cnt <= r_bit_cnt + 4'd1;
              end
            end
          end
          S_RDATA_ACK: begin
            if (w_scl_rise) begin
              r_ack <= ~w_sda;
            end else if (w_scl_fall) begin
              if (r_ack) begin
                r_rd    <= 1'b1;
                r_state <= S_RDATA;
              end else begin
                r_busy  <= 1'b0;
                r_state <= S_IGNORE;
              end
            end
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign sda_oe_o    = r_oe;
  assign reg_addr_o  = r_ptr;
  assign reg_wdata_o = r_wdata;
  assign reg_wr_o    = r_wr;
  assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_i2c_target.sv
// ============================================================================
// Module   : tb_i2c_target
// Purpose  : Directed bus transactions against i2c_target with a pointer/queue model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_i2c_target;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       sda_ctl = 1'b1;
  logic       sda_oe, wr, rd, busy;
  logic [7:0] addr, wdata, rdata;
  wire        sda_bus = sda_ctl & ~sda_oe;

  logic [7:0] rd_mem [256];
  assign rdata = rd_mem[addr];

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h40), .SYNC_STAGES(2)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .scl_i      (scl),
    .sda_i      (sda_bus),
    .sda_oe_o   (sda_oe),
    .reg_addr_o (addr),
    .reg_wdata_o(wdata),
    .reg_wr_o   (wr),
    .reg_rd_o   (rd),
    .reg_rdata_i(rdata),
    .busy_o     (busy)
  );

  int          n_vec = 0;
  int          n_err = 0;
  int          n_wr  = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  model_ptr = 8'h00;
  logic [7:0]  last_wr_addr = 8'h00, last_wr_data = 8'h00;
  logic [7:0]  tx [4];
  bit          silent = 1'b0;

  task automatic check1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  // Every-cycle comparison of strobes against the model queues.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr) begin
        logic [15:0] e;
        n_vec++;
        n_wr++;
        last_wr_addr = addr;
        last_wr_data = wdata;
        if (exp_wr.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_wr: addr %02h data %02h, none expected", addr, wdata);
        end else begin
          e = exp_wr.pop_front();
          if ({addr, wdata} !== e) begin
            n_err++;
            $display("FAIL wr_strobe: got addr %02h data %02h expected addr %02h data %02h",
                     addr, wdata, e[15:8], e[7:0]);
          end
        end
      end
      if (rd) begin
        logic [7:0] ea;
        n_vec++;
        if (exp_rd.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_rd: addr %02h, none expected", addr);
        end else begin
          ea = exp_rd.pop_front();
          if (addr !== ea) begin
            n_err++;
            $display("FAIL rd_strobe: got addr %02h expected %02h", addr, ea);
          end
        end
      end
      if (silent) begin
        n_vec++;
        if (sda_oe || busy || wr || rd) begin
          n_err++;
          $display("FAIL silent: oe %0b busy %0b wr %0b rd %0b expected all 0", sda_oe, busy, wr, rd);
        end
      end
    end
  end

  // One SCL period: SDA set up while low, sampled mid-high.
  task automatic clock_bit(input logic drive, output logic sampled);
    #20 sda_ctl = drive;
    #60 scl = 1'b1;
    #50 sampled = sda_bus;
    #50 scl = 1'b0;
  endtask

  task automatic bus_start();
    if (!(scl && sda_ctl)) begin
      #20 sda_ctl = 1'b1;
      #60 scl = 1'b1;
      #60;
    end else begin
      #60;
    end
    sda_ctl = 1'b0;
    #60 scl = 1'b0;
  endtask

  task automatic bus_stop();
    #20 sda_ctl = 1'b0;
    #60 scl = 1'b1;
    #60 sda_ctl = 1'b1;
    #60;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) clock_bit(b[i], s);
    clock_bit(1'b1, s);
    ack = ~s;
  endtask

  task automatic read_byte(input logic ack, output logic [7:0] b);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      clock_bit(1'b1, s);
      b[i] = s;
    end
    clock_bit(~ack, s);
  endtask

  task automatic wr_txn(input logic [6:0] ta, input logic [7:0] ra, input int n, input logic exp_ack);
    logic a;
    bus_start();
    write_byte({ta, 1'b0}, a);
    check1("addr_ack", a, exp_ack);
    check1("busy_after_addr", busy, exp_ack);
    write_byte(ra, a);
    check1("reg_ack", a, exp_ack);
    if (exp_ack) model_ptr = ra;
    for (int i = 0; i < n; i++) begin
      if (exp_ack) begin
        exp_wr.push_back({model_ptr, tx[i]});
        model_ptr = model_ptr + 8'd1;
      end
      write_byte(tx[i], a);
      check1("data_ack", a, exp_ack);
    end
    bus_stop();
    check1("busy_after_stop", busy, 1'b0);
    check1("oe_after_stop", sda_oe, 1'b0);
    check8("ptr_after_txn", addr, model_ptr);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       a, s;
    logic [7:0] b;
    int         wr_before;

    foreach (rd_mem[i]) rd_mem[i] = 8'(i) ^ 8'h3C;
    rd_mem[8'h06] = 8'hA5;
    rd_mem[8'h07] = 8'h5A;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check1("rst_oe", sda_oe, 1'b0);
    check1("rst_wr", wr, 1'b0);
    check1("rst_rd", rd, 1'b0);
    check1("rst_busy", busy, 1'b0);
    check8("rst_ptr", addr, 8'h00);
    check8("rst_wdata", wdata, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    #100;

    // Single write 0x40/W, reg 0xDE, data 0x4D
    tx[0] = 8'h4D;
    wr_before = n_wr;
    wr_txn(7'h40, 8'hDE, 1, 1'b1);
    check8("t1_wr_count", 8'(n_wr - wr_before), 8'd1);
    check8("t1_wr_addr", last_wr_addr, 8'hDE);
    check8("t1_wr_data", last_wr_data, 8'h4D);
    check8("t1_ptr", addr, 8'hDF);

    // Burst across the pointer wrap
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    wr_before = n_wr;
    wr_txn(7'h40, 8'hFE, 3, 1'b1);
    check8("t2_wr_count", 8'(n_wr - wr_before), 8'd3);
    check8("t2_last_addr", last_wr_addr, 8'h00);
    check8("t2_last_data", last_wr_data, 8'h33);
    check8("t2_ptr", addr, 8'h01);

    // Foreign address: nothing may react
    silent = 1'b1;
    wr_txn(7'h70, 8'hAA, 0, 1'b0);
    silent = 1'b0;
    check8("t3_ptr", addr, 8'h01);

    // Register set then repeated START read
    bus_start();
    write_byte(8'h80, a);
    check1("t4_addr_ack", a, 1'b1);
    write_byte(8'h06, a);
    check1("t4_reg_ack", a, 1'b1);
    model_ptr = 8'h06;
    bus_start();
`ifdef I2C_TARGET_READ_EN
    exp_rd.push_back(model_ptr);
    exp_rd.push_back(model_ptr + 8'd1);
    write_byte(8'h81, a);
    check1("t4_raddr_ack", a, 1'b1);
    read_byte(1'b1, b);
    check8("t4_byte0_model", b, rd_mem[model_ptr]);
    check8("t4_byte0", b, 8'hA5);
    model_ptr = model_ptr + 8'd1;
    read_byte(1'b0, b);
    check8("t4_byte1_model", b, rd_mem[model_ptr]);
    check8("t4_byte1", b, 8'h5A);
    model_ptr = model_ptr + 8'd1;
`else
    write_byte(8'h81, a);
    check1("t4_raddr_nack", a, 1'b0);
`endif
    #40;
    check1("t4_busy_ignore", busy, 1'b0);
    check1("t4_oe_ignore", sda_oe, 1'b0);
    bus_stop();
    check8("t4_ptr", addr, model_ptr);

    // STOP in the middle of a data byte
    wr_before = n_wr;
    bus_start();
    write_byte(8'h80, a);
    check1("t5_addr_ack", a, 1'b1);
    write_byte(8'h30, a);
    check1("t5_reg_ack", a, 1'b1);
    model_ptr = 8'h30;
    clock_bit(1'b0, s); clock_bit(1'b1, s); clock_bit(1'b0, s); clock_bit(1'b0, s);
    bus_stop();
    check8("t5_wr_count", 8'(n_wr - wr_before), 8'd0);
    check8("t5_ptr", addr, 8'h30);
    check1("t5_busy", busy, 1'b0);

    // Reset while the address ACK is on the bus
    bus_start();
    for (int i = 7; i >= 0; i--) clock_bit(i == 7, s);
    #20 sda_ctl = 1'b1;
    #60 scl = 1'b1;
    #50;
    check1("t6_ack_driven", sda_oe, 1'b1);
    rst_n = 1'b0;
    #1;
    check1("t6_oe_async", sda_oe, 1'b0);
    check1("t6_busy_async", busy, 1'b0);
    check8("t6_ptr_async", addr, 8'h00);
    #49 scl = 1'b0;
    #20 rst_n = 1'b1;
    model_ptr = 8'h00;
    #40;
    tx[0] = 8'h99;
    wr_txn(7'h40, 8'h12, 1, 1'b1);
    check8("t6_wr_addr", last_wr_addr, 8'h12);
    check8("t6_wr_data", last_wr_data, 8'h99);

    #200;
    check8("exp_wr_drained", 8'(exp_wr.size()), 8'd0);
    check8("exp_rd_drained", 8'(exp_rd.size()), 8'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
